elevator_scan_ctrl: RTL and testbench

//   Parametrised N-floor elevator controller. It is the next generation of the 4-floor controller.
//   - Latches floor-call pulses into a pending mask.
//   - Serves calls in SCAN (collective) order: keeps direction while calls remain ahead.
//   - Models one-floor travel time and a timed door-open dwell.
//   - Sits between call-button sync logic and the car-position display/status bus.

---
 rtl/elevator_scan_ctrl_if.sv | 22 ++
 rtl/elevator_scan_ctrl.sv | 110 +++++++++++
 tb/tb_elevator_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/elevator_scan_ctrl_if.sv
// rtl/elevator_scan_ctrl_if.sv - call inputs and car status bundle for the SCAN elevator controller
interface elevator_scan_ctrl_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLR_W      = $clog2(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] req;
    logic [FLR_W-1:0]      curr_flr;
    logic                  moving;
    logic                  dir_up;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output req,
        input  curr_flr, moving, dir_up, door_open, pending
    );

    modport slave (
        input  req,
        output curr_flr, moving, dir_up, door_open, pending
    );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - N-floor elevator controller serving latched calls in SCAN order
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS = 8,
    parameter int FLR_W      = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic                clk,
    input  logic                rst,
    elevator_scan_ctrl_if.slave bus
);
    localparam int TMAX  = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TMR_W = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t                state, state_n;
    logic [FLR_W-1:0]      flr, flr_n;
    logic                  up, up_n;
    logic [NUM_FLOORS-1:0] pend, pend_n;
    logic [TMR_W-1:0]      tmr, tmr_n;
    logic                  above, below;
    logic [FLR_W-1:0]      step_flr;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i > int'(flr))) above = 1'b1;
            if (pend[i] && (i < int'(flr))) below = 1'b1;
        end
    end

    // A call ahead always exists in MOVE, so this never steps past either end floor.
    assign step_flr = up ? flr + FLR_W'(1) : flr - FLR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            flr   <= '0;
            up    <= 1'b1;
            pend  <= '0;
            tmr   <= '0;
        end else begin
            state <= state_n;
            flr   <= flr_n;
            up    <= up_n;
            pend  <= pend_n;
            tmr   <= tmr_n;
        end
    end

    always_comb begin
        state_n = state;
        flr_n   = flr;
        up_n    = up;
        tmr_n   = tmr;
        pend_n  = pend | bus.req;
        case (state)
            IDLE: begin
                tmr_n = '0;
                if (pend[flr]) begin
                    state_n     = DOOR;
                    pend_n[flr] = 1'b0;
                end else if (up && above) begin
                    state_n = MOVE;
                end else if (!up && below) begin
                    state_n = MOVE;
                end else if (above) begin
                    state_n = MOVE;
                    up_n    = 1'b1;
                end else if (below) begin
                    state_n = MOVE;
                    up_n    = 1'b0;
                end
            end
            MOVE: begin
                if (tmr == TMR_W'(TRAVEL_CYC - 1)) begin
                    flr_n = step_flr;
                    tmr_n = '0;
                    if (pend[step_flr]) begin
                        state_n          = DOOR;
                        pend_n[step_flr] = 1'b0;
                    end
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            DOOR: begin
                // A fresh call for this floor holds the door instead of being latched.
                if (bus.req[flr]) begin
                    tmr_n       = '0;
                    pend_n[flr] = 1'b0;
                end else if (tmr == TMR_W'(DOOR_CYC - 1)) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.curr_flr  = flr;
    assign bus.moving    = (state == MOVE);
    assign bus.dir_up    = up;
    assign bus.door_open = (state == DOOR);
    assign bus.pending   = pend;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - vector-table and sequence bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;
    logic clk;
    logic rst;

    elevator_scan_ctrl_if #(.NUM_FLOORS(8)) bus ();
    elevator_scan_ctrl_if #(.NUM_FLOORS(5)) bus5 ();

    elevator_scan_ctrl #(.NUM_FLOORS(8), .TRAVEL_CYC(4), .DOOR_CYC(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    elevator_scan_ctrl #(.NUM_FLOORS(5), .TRAVEL_CYC(4), .DOOR_CYC(6)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        int         cyc;
        logic [2:0] flr;
        logic       mv;
        logic       up;
        logic       dr;
        logic [7:0] pend;
    } vec_t;

    vec_t tbl[32];
    int   total = 0;
    int   bad   = 0;
    logic mv_seen;
    logic [2:0] p_flr;
    logic p_up, p_mv;
    int   max_f, viol;

    function automatic logic [31:0] st8();
        return {18'd0, bus.curr_flr, bus.moving, bus.dir_up, bus.door_open, bus.pending};
    endfunction

    function automatic logic [31:0] ex8(input logic [2:0] f, input logic m, input logic u,
                                        input logic d, input logic [7:0] p);
        return {18'd0, f, m, u, d, p};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] r, input int n);
        for (int k = 0; k < n; k++) begin
            bus.req = (k == 0) ? r : 8'h00;
            @(posedge clk);
            @(negedge clk);
            mv_seen = mv_seen | bus.moving;
        end
        bus.req = 8'h00;
    endtask

    task automatic run5(input logic [4:0] r, input int n);
        int d;
        for (int k = 0; k < n; k++) begin
            bus5.req = (k == 0) ? r : 5'h00;
            @(posedge clk);
            @(negedge clk);
            if (bus5.curr_flr > 3'd4) viol++;
            if (int'(bus5.curr_flr) > max_f) max_f = int'(bus5.curr_flr);
            d = int'(bus5.curr_flr) - int'(p_flr);
            if (d > 1 || d < -1) viol++;
            if (bus5.dir_up != p_up && p_mv) viol++;
            p_flr = bus5.curr_flr;
            p_up  = bus5.dir_up;
            p_mv  = bus5.moving;
        end
        bus5.req = 5'h00;
    endtask

    initial begin
        // Single-call trip, same-floor idle call, reversal down, then SCAN stops 6,7 and reverse to 1.
        tbl[0]  = '{8'h08, 1,  3'd0, 1'b0, 1'b1, 1'b0, 8'h08};
        tbl[1]  = '{8'h00, 1,  3'd0, 1'b1, 1'b1, 1'b0, 8'h08};
        tbl[2]  = '{8'h00, 4,  3'd1, 1'b1, 1'b1, 1'b0, 8'h08};
        tbl[3]  = '{8'h00, 4,  3'd2, 1'b1, 1'b1, 1'b0, 8'h08};
        tbl[4]  = '{8'h00, 3,  3'd2, 1'b1, 1'b1, 1'b0, 8'h08};
        tbl[5]  = '{8'h00, 1,  3'd3, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[6]  = '{8'h00, 5,  3'd3, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[7]  = '{8'h00, 1,  3'd3, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{8'h08, 1,  3'd3, 1'b0, 1'b1, 1'b0, 8'h08};
        tbl[9]  = '{8'h00, 1,  3'd3, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[10] = '{8'h00, 6,  3'd3, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{8'h01, 1,  3'd3, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[12] = '{8'h00, 1,  3'd3, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[13] = '{8'h00, 4,  3'd2, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[14] = '{8'h00, 8,  3'd0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[15] = '{8'h00, 6,  3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[16] = '{8'h10, 1,  3'd0, 1'b0, 1'b0, 1'b0, 8'h10};
        tbl[17] = '{8'h00, 1,  3'd0, 1'b1, 1'b1, 1'b0, 8'h10};
        tbl[18] = '{8'h00, 16, 3'd4, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[19] = '{8'h42, 1,  3'd4, 1'b0, 1'b1, 1'b1, 8'h42};
        tbl[20] = '{8'h00, 5,  3'd4, 1'b0, 1'b1, 1'b0, 8'h42};
        tbl[21] = '{8'h00, 1,  3'd4, 1'b1, 1'b1, 1'b0, 8'h42};
        tbl[22] = '{8'h80, 1,  3'd4, 1'b1, 1'b1, 1'b0, 8'hC2};
        tbl[23] = '{8'h00, 3,  3'd5, 1'b1, 1'b1, 1'b0, 8'hC2};
        tbl[24] = '{8'h00, 4,  3'd6, 1'b0, 1'b1, 1'b1, 8'h82};
        tbl[25] = '{8'h00, 6,  3'd6, 1'b0, 1'b1, 1'b0, 8'h82};
        tbl[26] = '{8'h00, 1,  3'd6, 1'b1, 1'b1, 1'b0, 8'h82};
        tbl[27] = '{8'h00, 4,  3'd7, 1'b0, 1'b1, 1'b1, 8'h02};
        tbl[28] = '{8'h00, 6,  3'd7, 1'b0, 1'b1, 1'b0, 8'h02};
        tbl[29] = '{8'h00, 1,  3'd7, 1'b1, 1'b0, 1'b0, 8'h02};
        tbl[30] = '{8'h00, 24, 3'd1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[31] = '{8'h00, 6,  3'd1, 1'b0, 1'b0, 1'b0, 8'h00};

        rst      = 1'b1;
        bus.req  = 8'h00;
        bus5.req = 5'h00;
        mv_seen  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_state", st8(), ex8(3'd0, 1'b0, 1'b1, 1'b0, 8'h00));

        for (int i = 0; i < 32; i++) begin
            apply(tbl[i].req, tbl[i].cyc);
            chk($sformatf("vec%0d", i), st8(),
                ex8(tbl[i].flr, tbl[i].mv, tbl[i].up, tbl[i].dr, tbl[i].pend));
        end

        // Door hold: restart at timer=4 keeps the door open six more cycles.
        apply(8'h20, 1);
        chk("t4_latch", st8(), ex8(3'd1, 1'b0, 1'b0, 1'b0, 8'h20));
        apply(8'h00, 1);
        chk("t4_move", st8(), ex8(3'd1, 1'b1, 1'b1, 1'b0, 8'h20));
        apply(8'h00, 16);
        chk("t4_arrive", st8(), ex8(3'd5, 1'b0, 1'b1, 1'b1, 8'h00));
        apply(8'h00, 4);
        apply(8'h20, 1);
        chk("t4_restart", st8(), ex8(3'd5, 1'b0, 1'b1, 1'b1, 8'h00));
        apply(8'h00, 5);
        chk("t4_held", st8(), ex8(3'd5, 1'b0, 1'b1, 1'b1, 8'h00));
        apply(8'h00, 1);
        chk("t4_close", st8(), ex8(3'd5, 1'b0, 1'b1, 1'b0, 8'h00));

        // Same-floor idle call, re-requested on the very edge it is cleared.
        mv_seen = 1'b0;
        apply(8'h20, 1);
        chk("t5_latch", st8(), ex8(3'd5, 1'b0, 1'b1, 1'b0, 8'h20));
        apply(8'h20, 1);
        chk("t5_door", st8(), ex8(3'd5, 1'b0, 1'b1, 1'b1, 8'h00));
        apply(8'h00, 6);
        chk("t5_idle", st8(), ex8(3'd5, 1'b0, 1'b1, 1'b0, 8'h00));
        chk("t5_never_moving", {31'd0, mv_seen}, 32'd0);

        // Asynchronous reset mid-travel at floor 2.
        apply(8'h02, 1);
        apply(8'h00, 1);
        apply(8'h00, 12);
        apply(8'h00, 2);
        chk("t1_pre_reset", st8(), ex8(3'd2, 1'b1, 1'b0, 1'b0, 8'h02));
        rst = 1'b1;
        #1;
        chk("t1_reset_async", st8(), ex8(3'd0, 1'b0, 1'b1, 1'b0, 8'h00));
        @(negedge clk);
        rst = 1'b0;
        apply(8'h00, 2);
        chk("t1_after_reset", st8(), ex8(3'd0, 1'b0, 1'b1, 1'b0, 8'h00));

        // Five-floor instance: top then ground, no overrun or wrap, reversal only from IDLE.
        p_flr = bus5.curr_flr;
        p_up  = bus5.dir_up;
        p_mv  = bus5.moving;
        max_f = 0;
        viol  = 0;
        run5(5'h10, 26);
        run5(5'h01, 26);
        chk("t6_max_floor", max_f, 32'd4);
        chk("t6_violations", viol, 32'd0);
        chk("t6_final", {22'd0, bus5.curr_flr, bus5.moving, bus5.dir_up, bus5.door_open, bus5.pending},
            {22'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
